// File: rtl/debug_controller.sv
// Debug controller: run/halt/single-step control of a core, PC breakpoint,
// and a register-file dump streamed out over a valid/ready port.
module debug_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic        core_en,
  input  logic [31:0] fetchPC,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  output logic [4:0]  debug_reg_select,
  input  logic [31:0] debug_reg_out,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] instret
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 5;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  localparam logic [1:0] CAUSE_RESET = 2'b00;
  localparam logic [1:0] CAUSE_CMD   = 2'b01;
  localparam logic [1:0] CAUSE_STEP  = 2'b10;
  localparam logic [1:0] CAUSE_BP    = 2'b11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(31);

  typedef enum logic [2:0] {
    S_HALT,
    S_RUN,
    S_STEP,
    S_DUMP_LOAD,
    S_DUMP_SEND
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] index, index_next;
  logic             first_run, first_run_next;
  logic [1:0]       cause_next;
  logic [XLEN-1:0]  data_next;
  logic             last_next;
  logic             accept;
  logic             bp_hit;

  // Control outputs decoded straight from the state register
  assign cmd_ready        = (state == S_HALT) || (state == S_RUN);
  assign accept           = cmd_valid && cmd_ready;
  assign bp_hit           = (state == S_RUN) && bp_en && (fetchPC == bp_addr) && !first_run;
  assign core_en          = !reset && ((state == S_STEP) || ((state == S_RUN) && !bp_hit));
  assign halted           = (state == S_HALT);
  assign dump_valid       = (state == S_DUMP_SEND);
  assign debug_reg_select = index;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HALT;
      index      <= '0;
      first_run  <= 1'b0;
      halt_cause <= CAUSE_RESET;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      instret    <= '0;
    end else begin
      state      <= state_next;
      index      <= index_next;
      first_run  <= first_run_next;
      halt_cause <= cause_next;
      dump_data  <= data_next;
      dump_last  <= last_next;
      if (core_en) instret <= instret + XLEN'(1);
    end
  end

  // A breakpoint outranks any command accepted in the same RUN cycle
  always_comb begin
    state_next     = state;
    index_next     = index;
    first_run_next = 1'b0;
    cause_next     = halt_cause;
    data_next      = dump_data;
    last_next      = dump_last;
    unique case (state)
      S_HALT: begin
        if (accept) begin
          unique case (cmd_op)
            OP_RUN: begin
              state_next     = S_RUN;
              first_run_next = 1'b1;
            end
            OP_STEP: state_next = S_STEP;
            OP_DUMP: begin
              state_next = S_DUMP_LOAD;
              index_next = '0;
            end
            OP_HALT: state_next = S_HALT;
            default: state_next = S_HALT;
          endcase
        end
      end
      S_RUN: begin
        if (bp_hit) begin
          state_next = S_HALT;
          cause_next = CAUSE_BP;
        end else if (accept && (cmd_op == OP_HALT)) begin
          state_next = S_HALT;
          cause_next = CAUSE_CMD;
        end
      end
      S_STEP: begin
        state_next = S_HALT;
        cause_next = CAUSE_STEP;
      end
      S_DUMP_LOAD: begin
        data_next  = debug_reg_out;
        last_next  = (index == LAST_IDX);
        state_next = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        if (dump_ready) begin
          if (index == LAST_IDX) begin
            state_next = S_HALT;
            index_next = '0;
          end else begin
            state_next = S_DUMP_LOAD;
            index_next = index + IDX_W'(1);
          end
        end
      end
      default: state_next = S_HALT;
    endcase
  end

endmodule
